// File: rtl/aemb_wb_pkg.sv
// Shared types and constants for the aeMB two-master Wishbone arbiter.
// The arbiter and its watchdog both import this package.
package aemb_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Watchdog counter width; stays at least one bit wide when the watchdog is disabled.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/aemb_wb_watchdog.sv
// Stall watchdog: counts unterminated strobe cycles of the current owner and
// fires a one-cycle timeout when the count reaches TIMEOUT (0 disables it).
module aemb_wb_watchdog
  import aemb_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic term_i,
  output logic timeout_o
);

  localparam int CW = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  // A slave termination in the limit cycle takes priority over the timeout.
  assign fire      = (TIMEOUT != 0) && active_i && !term_i && (cnt_q == LIMIT);
  assign timeout_o = fire;

  always_comb begin
    cnt_d = '0;
    if (active_i && !term_i && !fire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aemb_wb_arbiter.sv
// Round-robin arbiter merging the aeMB instruction and data Wishbone masters
// onto one slave bus; the grant is held for the whole cyc of the owner.
module aemb_wb_arbiter
  import aemb_wb_pkg::*;
#(
  parameter int Aw      = 32,
  parameter int Dw      = 32,
  parameter int SELw    = Dw / 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   i_adr_i,
  input  logic [Dw-1:0]   i_dat_i,
  input  logic [SELw-1:0] i_sel_i,
  input  logic            i_cyc_i,
  input  logic            i_stb_i,
  input  logic            i_we_i,
  input  logic [2:0]      i_cti_i,
  input  logic [1:0]      i_bte_i,
  output logic [Dw-1:0]   i_dat_o,
  output logic            i_ack_o,
  output logic            i_err_o,
  output logic            i_rty_o,
  input  logic [Aw-1:0]   d_adr_i,
  input  logic [Dw-1:0]   d_dat_i,
  input  logic [SELw-1:0] d_sel_i,
  input  logic            d_cyc_i,
  input  logic            d_stb_i,
  input  logic            d_we_i,
  input  logic [2:0]      d_cti_i,
  input  logic [1:0]      d_bte_i,
  output logic [Dw-1:0]   d_dat_o,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic            d_rty_o,
  output logic [Aw-1:0]   s_adr_o,
  output logic [Dw-1:0]   s_dat_o,
  output logic [SELw-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [Dw-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o
);

  // Handshake: a master requests with cyc&stb; a beat completes in the cycle the
  // slave raises ack, err or rty while that master owns the bus. Ownership ends
  // only when the owner drops cyc, so multi-beat locked sequences stay atomic.

  arb_state_e state_q, state_d;
  logic [1:0] last_gnt_q, last_gnt_d;
  logic       req_i, req_d, own_i, own_d;
  logic       term, wd_active, timeout;

  assign req_i     = i_cyc_i & i_stb_i;
  assign req_d     = d_cyc_i & d_stb_i;
  assign own_i     = (state_q == OWN_I);
  assign own_d     = (state_q == OWN_D);
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign wd_active = (own_i & req_i) | (own_d & req_d);

  aemb_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .active_i  (wd_active),
    .term_i    (term),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_I;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = (last_gnt_q == GNT_I) ? OWN_D : OWN_I;
        end else if (req_i) begin
          state_d = OWN_I;
        end else if (req_d) begin
          state_d = OWN_D;
        end
      end
      OWN_I: begin
        if (!i_cyc_i) begin
          last_gnt_d = GNT_I;
          state_d    = req_d ? OWN_D : IDLE;
        end
      end
      OWN_D: begin
        if (!d_cyc_i) begin
          last_gnt_d = GNT_D;
          state_d    = req_i ? OWN_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: everything is zero unless a master owns the bus; a timeout
  // withdraws cyc/stb for its single cycle and is reported as err.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cti_o = CTI_CLASSIC;
    s_bte_o = 2'b00;
    i_dat_o = '0;
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    i_rty_o = 1'b0;
    d_dat_o = '0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    d_rty_o = 1'b0;
    grant_o = GNT_NONE;
    if (own_i) begin
      s_adr_o = i_adr_i;
      s_dat_o = i_dat_i;
      s_sel_o = i_sel_i;
      s_cyc_o = i_cyc_i & ~timeout;
      s_stb_o = req_i & ~timeout;
      s_we_o  = i_we_i;
      s_cti_o = i_cti_i;
      s_bte_o = i_bte_i;
      i_dat_o = s_dat_i;
      i_ack_o = s_ack_i;
      i_err_o = s_err_i | timeout;
      i_rty_o = s_rty_i;
      grant_o = GNT_I;
    end else if (own_d) begin
      s_adr_o = d_adr_i;
      s_dat_o = d_dat_i;
      s_sel_o = d_sel_i;
      s_cyc_o = d_cyc_i & ~timeout;
      s_stb_o = req_d & ~timeout;
      s_we_o  = d_we_i;
      s_cti_o = d_cti_i;
      s_bte_o = d_bte_i;
      d_dat_o = s_dat_i;
      d_ack_o = s_ack_i;
      d_err_o = s_err_i | timeout;
      d_rty_o = s_rty_i;
      grant_o = GNT_D;
    end
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Bench for aemb_wb_arbiter: directed scenarios plus random two-master traffic,
// every cycle compared against an ownership/round-robin model of the arbiter.
module tb_aemb_wb_arbiter;
  import aemb_wb_pkg::*;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] i_adr_i = '0, d_adr_i = '0, i_dat_i = '0, d_dat_i = '0;
  logic [3:0]  i_sel_i = '0, d_sel_i = '0;
  logic        i_cyc_i = 1'b0, d_cyc_i = 1'b0, i_stb_i = 1'b0, d_stb_i = 1'b0;
  logic        i_we_i = 1'b0, d_we_i = 1'b0;
  logic [2:0]  i_cti_i = '0, d_cti_i = '0;
  logic [1:0]  i_bte_i = '0, d_bte_i = '0;
  logic [31:0] i_dat_o, d_dat_o;
  logic        i_ack_o, d_ack_o, i_err_o, d_err_o, i_rty_o, d_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [1:0]  grant_o;

  aemb_wb_arbiter #(.Aw(32), .Dw(32), .SELw(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_adr_i(i_adr_i), .i_dat_i(i_dat_i), .i_sel_i(i_sel_i), .i_cyc_i(i_cyc_i),
    .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_cti_i(i_cti_i), .i_bte_i(i_bte_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_rty_o(i_rty_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_cyc_i(d_cyc_i),
    .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_cti_i(d_cti_i), .d_bte_i(d_bte_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rty_o(d_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];     // expected sequence of grant_o values
  logic [1:0] gnt_log[$];   // observed grant_o changes
  logic [1:0] mgnt_log[$];  // model grant changes

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, 128'(gnt_log.size()), 128'(exp_q.size()));
    check({name, "_model_len"}, 128'(mgnt_log.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < gnt_log.size()) check($sformatf("%s_%0d", name, k), 128'(gnt_log[k]), 128'(exp_q[k]));
      if (k < mgnt_log.size()) check($sformatf("%s_model_%0d", name, k), 128'(mgnt_log[k]), 128'(exp_q[k]));
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    mgnt_log.delete();
    exp_q.delete();
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_own = 0;    // 0 none, 1 instruction master, 2 data master
  int m_last = 1;   // master that owned the bus most recently
  int m_wait = 0;   // unterminated strobe cycles of the owner
  logic [1:0] prev_gnt = 2'b00, prev_mgnt = 2'b00;

  task automatic model_step();
    bit ri, rd, cx, sx, act, term, tmo;
    logic [75:0] exp_s;
    logic [34:0] exp_i, exp_d;
    logic [1:0]  exp_g;
    ri   = i_cyc_i && i_stb_i;
    rd   = d_cyc_i && d_stb_i;
    cx   = (m_own == 1) ? i_cyc_i : (m_own == 2) ? d_cyc_i : 1'b0;
    sx   = (m_own == 1) ? i_stb_i : (m_own == 2) ? d_stb_i : 1'b0;
    act  = cx && sx;
    term = s_ack_i || s_err_i || s_rty_i;
    tmo  = act && !term && (m_wait == TMO);
    exp_s = '0;
    exp_i = '0;
    exp_d = '0;
    exp_g = 2'b00;
    if (m_own == 1) begin
      exp_s = {i_adr_i, i_dat_i, i_sel_i, i_cyc_i && !tmo, act && !tmo, i_we_i, i_cti_i, i_bte_i};
      exp_i = {s_dat_i, s_ack_i, s_err_i || tmo, s_rty_i};
      exp_g = 2'b01;
    end else if (m_own == 2) begin
      exp_s = {d_adr_i, d_dat_i, d_sel_i, d_cyc_i && !tmo, act && !tmo, d_we_i, d_cti_i, d_bte_i};
      exp_d = {s_dat_i, s_ack_i, s_err_i || tmo, s_rty_i};
      exp_g = 2'b10;
    end
    check("grant", 128'(grant_o), 128'(exp_g));
    check("s_bus", 128'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o}), 128'(exp_s));
    check("i_resp", 128'({i_dat_o, i_ack_o, i_err_o, i_rty_o}), 128'(exp_i));
    check("d_resp", 128'({d_dat_o, d_ack_o, d_err_o, d_rty_o}), 128'(exp_d));
    if (grant_o != prev_gnt) begin
      gnt_log.push_back(grant_o);
      prev_gnt = grant_o;
    end
    if (exp_g != prev_mgnt) begin
      mgnt_log.push_back(exp_g);
      prev_mgnt = exp_g;
    end
    // ownership for the next cycle
    if (reset) begin
      m_own = 0; m_last = 1; m_wait = 0;
    end else if (m_own == 0) begin
      if (ri && rd) m_own = (m_last == 1) ? 2 : 1;
      else if (ri) m_own = 1;
      else if (rd) m_own = 2;
      m_wait = 0;
    end else if (!cx) begin
      m_last = m_own;
      m_own  = ((m_own == 1) ? rd : ri) ? 3 - m_own : 0;
      m_wait = 0;
    end else begin
      m_wait = (act && !term && !tmo) ? m_wait + 1 : 0;
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- slave responder ----------------
  int   lat_lo = 0, lat_hi = 0, cur_lat = 0, wait_cnt = 0;
  bit   slave_mute = 1'b0, slave_rand_resp = 1'b0, slave_fixed = 1'b0;
  logic [31:0] slave_dat = '0;

  initial begin
    int r;
    bit active;
    forever begin
      @(posedge clk);
      #2;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      s_dat_i = slave_fixed ? slave_dat : $urandom;
      #1;
      active = !reset && ((grant_o == 2'b01 && i_cyc_i && i_stb_i) ||
                          (grant_o == 2'b10 && d_cyc_i && d_stb_i));
      if (active) begin
        if (!slave_mute && wait_cnt >= cur_lat) begin
          r = $urandom_range(0, 15);
          if (slave_rand_resp && r == 0) s_err_i = 1'b1;
          else if (slave_rand_resp && r == 1) s_rty_i = 1'b1;
          else s_ack_i = 1'b1;
          wait_cnt = 0;
          cur_lat  = $urandom_range(lat_lo, lat_hi);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic set_slave(input int lo, input int hi, input bit mute, input bit rnd);
    lat_lo = lo; lat_hi = hi; cur_lat = lo; slave_mute = mute; slave_rand_resp = rnd;
  endtask

  // ---------------- master drivers ----------------
  task automatic drive_master(input int m, input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic [2:0] cti, input logic [1:0] bte);
    if (m == 0) begin
      i_cyc_i = cyc; i_stb_i = stb; i_we_i = we; i_adr_i = adr;
      i_dat_i = dat; i_sel_i = sel; i_cti_i = cti; i_bte_i = bte;
    end else begin
      d_cyc_i = cyc; d_stb_i = stb; d_we_i = we; d_adr_i = adr;
      d_dat_i = dat; d_sel_i = sel; d_cti_i = cti; d_bte_i = bte;
    end
  endtask

  function automatic logic term_of(input int m);
    return (m == 0) ? (i_ack_o | i_err_o | i_rty_o) : (d_ack_o | d_err_o | d_rty_o);
  endfunction

  function automatic logic err_of(input int m);
    return (m == 0) ? i_err_o : d_err_o;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with cyc low.
  task automatic master_txn(input int m, input logic [31:0] adr, input int beats,
                            input bit rmw, input logic we);
    logic [2:0] cti;
    int budget;
    bit err_seen;
    err_seen = 1'b0;
    for (int b = 0; b < beats && !err_seen; b++) begin
      cti = (beats == 1 || rmw) ? CTI_CLASSIC : (b == beats - 1) ? CTI_EOB : 3'b010;
      drive_master(m, 1'b1, 1'b1, rmw ? (b == beats - 1) : we,
                   rmw ? adr : adr + 32'(4 * b), $urandom, 4'($urandom_range(1, 15)),
                   cti, 2'($urandom_range(0, 3)));
      budget = 60;
      do begin
        @(negedge clk);
        budget--;
      end while (!term_of(m) && budget > 0);
      check($sformatf("m%0d_beat_terminated", m), 128'(term_of(m)), 128'(1'b1));
      err_seen = err_of(m) || !term_of(m);
      @(posedge clk);
      #1;
    end
    drive_master(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  task automatic run_random(input int m, input int n_txn);
    bit rmw;
    for (int n = 0; n < n_txn; n++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      rmw = ($urandom_range(0, 3) == 0);
      master_txn(m, 32'($urandom) & 32'hFFFF_FFF0, rmw ? 2 : $urandom_range(1, 4),
                 rmw, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_grant", 128'(grant_o), 128'(2'b00));
    check("rst_s_cyc_stb", 128'({s_cyc_o, s_stb_o}), 128'(2'b00));
    check("rst_i_dat", 128'(i_dat_o), 128'(32'h0));

    // single instruction read, ack three cycles after the request
    set_slave(2, 2, 1'b0, 1'b0);
    slave_fixed = 1'b1;
    slave_dat   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hf, CTI_CLASSIC, 2'b00);
    @(negedge clk); check("t1_stb_c0", 128'(s_stb_o), 128'(1'b0));
    @(negedge clk); check("t1_stb_c1", 128'(s_stb_o), 128'(1'b1));
    check("t1_adr_c1", 128'(s_adr_o), 128'(32'h100));
    @(negedge clk); check("t1_ack_c2", 128'(i_ack_o), 128'(1'b0));
    @(negedge clk); check("t1_ack_c3", 128'(i_ack_o), 128'(1'b1));
    check("t1_dat_c3", 128'(i_dat_o), 128'(32'hDEAD_BEEF));
    check("t1_dack_c3", 128'(d_ack_o), 128'(1'b0));
    @(posedge clk);
    #1;
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    @(negedge clk); check("t1_grant_drop", 128'(grant_o), 128'(2'b01));
    @(negedge clk); check("t1_grant_idle", 128'(grant_o), 128'(2'b00));
    slave_fixed = 1'b0;

    // simultaneous requests right after reset: data first, then straight to instruction
    @(posedge clk);
    #1;
    pulse_reset();
    clear_logs();
    set_slave(0, 2, 1'b0, 1'b0);
    fork
      master_txn(0, 32'h200, 1, 1'b0, 1'b0);
      master_txn(1, 32'h300, 1, 1'b0, 1'b1);
    join
    repeat (3) @(negedge clk);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    check_seq("t2_grant_seq");

    // back-to-back fairness with single-cycle acks
    @(posedge clk);
    #1;
    clear_logs();
    set_slave(0, 0, 1'b0, 1'b0);
    fork
      for (int n = 0; n < 3; n++) begin master_txn(0, 32'h400, 1, 1'b0, 1'b0); @(posedge clk); #1; end
      for (int n = 0; n < 3; n++) begin master_txn(1, 32'h500, 1, 1'b0, 1'b0); @(posedge clk); #1; end
    join
    repeat (3) @(negedge clk);
    for (int n = 0; n < 3; n++) begin exp_q.push_back(2'b10); exp_q.push_back(2'b01); end
    exp_q.push_back(2'b00);
    check_seq("t3_fair_seq");

    // locked read-modify-write on the data port while instruction waits
    @(posedge clk);
    #1;
    clear_logs();
    set_slave(1, 3, 1'b0, 1'b0);
    fork
      master_txn(1, 32'h20, 2, 1'b1, 1'b0);
      begin @(posedge clk); #1; master_txn(0, 32'h600, 1, 1'b0, 1'b0); end
    join
    repeat (3) @(negedge clk);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    check_seq("t4_rmw_seq");

    // watchdog: slave never answers an instruction read
    @(posedge clk);
    #1;
    set_slave(0, 0, 1'b1, 1'b0);
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 4'hf, CTI_CLASSIC, 2'b00);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t5_err_c%0d", c), 128'(i_err_o), 128'(c == 5));
    end
    check("t5_stb_low", 128'({s_cyc_o, s_stb_o}), 128'(2'b00));
    check("t5_grant_err", 128'(grant_o), 128'(2'b01));
    @(posedge clk);
    #1;
    i_stb_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5_grant_held", 128'({grant_o, s_cyc_o, i_err_o}), 128'({2'b01, 1'b1, 1'b0}));
    end
    @(posedge clk);
    #1;
    i_cyc_i = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_grant_release", 128'(grant_o), 128'(2'b00));

    // reset while the data master owns the bus with strobe high
    @(posedge clk);
    #1;
    drive_master(1, 1'b1, 1'b1, 1'b1, 32'h800, 32'h1234, 4'hf, CTI_CLASSIC, 2'b00);
    @(negedge clk);
    @(negedge clk); check("t6_owned", 128'({grant_o, s_stb_o}), 128'({2'b10, 1'b1}));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_s_bus", 128'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o}), 128'(0));
    check("t6_grant", 128'(grant_o), 128'(2'b00));
    check("t6_d_resp", 128'({d_dat_o, d_ack_o, d_err_o, d_rty_o}), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);

    // random concurrent traffic, latencies straddling the watchdog limit
    set_slave(0, 6, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    fork
      run_random(0, 25);
      run_random(1, 25);
    join
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: run did not complete, errors so far %0d", errors);
    $fatal(1, "time limit reached");
  end

endmodule
